// File: rtl/lcd_text_sequencer_if.sv
// rtl/lcd_text_sequencer_if.sv - refresh, character buffer and lcd controller handshake bundle
interface lcd_text_sequencer_if;
  logic       iREFRESH;
  logic [4:0] oCHAR_ADDR;
  logic [7:0] iCHAR;
  logic       oBUSY;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_START;
  logic       iLCD_DONE;

  modport master (
    input  iREFRESH, iCHAR, iLCD_DONE,
    output oCHAR_ADDR, oBUSY, oLCD_DATA, oLCD_RS, oLCD_START
  );

  modport slave (
    output iREFRESH, iCHAR, iLCD_DONE,
    input  oCHAR_ADDR, oBUSY, oLCD_DATA, oLCD_RS, oLCD_START
  );
endinterface

// File: rtl/lcd_text_sequencer.sv
// rtl/lcd_text_sequencer.sv - HD44780 init plus 32-character redraw feeder for the lcd controller
module lcd_text_sequencer #(
  parameter int unsigned DLY_CYCLES = 262142
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  lcd_text_sequencer_if.master bus
);
  localparam int unsigned CW = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(DLY_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, WAIT_DONE, DELAY, IDLE} state_t;

  state_t        state;
  logic [5:0]    idx;
  logic [CW-1:0] dly_cnt;
  logic          pend;
  logic          start;
  logic [7:0]    data;
  logic          rs;
  logic          busy;
  logic [4:0]    char_addr;
  logic [7:0]    item_data;
  logic          item_rs;

  // Script positions 5..20 map to line 1 cells, 22..37 to line 2 cells.
  always_comb begin
    char_addr = 5'd0;
    if (idx >= 6'd5 && idx <= 6'd20)
      char_addr = 5'(idx - 6'd5);
    else if (idx >= 6'd22 && idx <= 6'd37)
      char_addr = 5'(idx - 6'd6);
  end

  always_comb begin
    item_rs   = 1'b0;
    item_data = 8'h00;
    case (idx)
      6'd0:    item_data = 8'h38;
      6'd1:    item_data = 8'h0C;
      6'd2:    item_data = 8'h01;
      6'd3:    item_data = 8'h06;
      6'd4:    item_data = 8'h80;
      6'd21:   item_data = 8'hC0;
      default: begin
        item_rs   = 1'b1;
        item_data = bus.iCHAR;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= LOAD;
      idx     <= 6'd0;
      dly_cnt <= '0;
      pend    <= 1'b0;
      start   <= 1'b0;
      data    <= 8'h00;
      rs      <= 1'b0;
      busy    <= 1'b1;
    end else begin
      // Requests arriving mid-draw collapse into a single deferred redraw.
      if (bus.iREFRESH && busy)
        pend <= 1'b1;
      case (state)
        LOAD: begin
          data  <= item_data;
          rs    <= item_rs;
          start <= 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.iLCD_DONE) begin
            start   <= 1'b0;
            dly_cnt <= '0;
            state   <= DELAY;
          end
        end
        DELAY: begin
          if (dly_cnt == DLY_LAST) begin
            if (idx == 6'd37) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= idx + 6'd1;
              state <= LOAD;
            end
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        IDLE: begin
          // Redraws restart at the line 1 home command; init is never repeated.
          if (bus.iREFRESH || pend) begin
            idx   <= 6'd4;
            pend  <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.oCHAR_ADDR = char_addr;
  assign bus.oBUSY      = busy;
  assign bus.oLCD_DATA  = data;
  assign bus.oLCD_RS    = rs;
  assign bus.oLCD_START = start;
endmodule

// File: tb/tb_lcd_text_sequencer.sv
// tb/tb_lcd_text_sequencer.sv - randomized bench for lcd_text_sequencer against a transfer-list model
module tb_lcd_text_sequencer;
  localparam int DLY = 4;

  logic clk;
  logic rst;
  lcd_text_sequencer_if bus();

  lcd_text_sequencer #(.DLY_CYCLES(DLY)) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mem [32];
  assign bus.iCHAR = mem[bus.oCHAR_ADDR];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // lcd controller model: DONE after lat cycles of START, dropped with START.
  int lat = 3;
  logic done_force = 1'b0;
  int hi = 0;
  always @(negedge clk) begin
    if (rst) begin
      hi = 0;
      bus.iLCD_DONE = 1'b0;
    end else begin
      if (bus.oLCD_START) hi++;
      else hi = 0;
      bus.iLCD_DONE = (bus.oLCD_START && hi >= lat) || done_force;
    end
  end

  // Transfer monitor: records every START rise and checks timing/holding.
  logic [8:0] got [$];
  logic [8:0] exp_q [$];
  logic [8:0] cap;
  logic prev_start = 1'b0;
  bit   gap_valid = 1'b0;
  int   hi_m = 0, low = 0, viol = 0;
  always @(negedge clk) begin
    if (rst) begin
      gap_valid = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (bus.oLCD_START && !prev_start) begin
        got.push_back({bus.oLCD_RS, bus.oLCD_DATA});
        cap = {bus.oLCD_RS, bus.oLCD_DATA};
        if (gap_valid) check("gap", 32'(low), 32'(DLY + 1));
        hi_m = 1;
        viol = 0;
      end else if (bus.oLCD_START) begin
        hi_m++;
        if ({bus.oLCD_RS, bus.oLCD_DATA} != cap) viol++;
      end else if (prev_start) begin
        check("high_len", 32'(hi_m), 32'(lat));
        check("hold", 32'(viol), 32'd0);
        gap_valid = 1'b1;
        low = 1;
      end else begin
        low++;
      end
      if (!bus.oBUSY) gap_valid = 1'b0;
      prev_start = bus.oLCD_START;
    end
  end

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
  endtask

  task automatic add_draw(input bit with_init);
    if (with_init) begin
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h001);
      exp_q.push_back(9'h006);
    end
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, mem[i]});
    exp_q.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, mem[i]});
  endtask

  task automatic compare_list(input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_item%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_idle(input string tag, input int budget, input int want);
    bit ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (!bus.oBUSY && got.size() >= want) ok = 1'b1;
    end
    check({tag, "_reach_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic pulse_refresh(input bit from_idle);
    @(negedge clk);
    bus.iREFRESH = 1'b1;
    @(negedge clk);
    bus.iREFRESH = 1'b0;
    if (from_idle) check("busy_rise", 32'(bus.oBUSY), 32'd1);
  endtask

  task automatic new_draw_expect();
    got.delete();
    exp_q.delete();
    randomize_mem();
    add_draw(1'b0);
  endtask

  initial begin
    bus.iREFRESH = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'h41 + 8'(i);
    repeat (3) @(negedge clk);
    check("rst_start", 32'(bus.oLCD_START), 32'd0);
    check("rst_data",  32'(bus.oLCD_DATA),  32'h00);
    check("rst_rs",    32'(bus.oLCD_RS),    32'd0);
    check("rst_busy",  32'(bus.oBUSY),      32'd1);
    check("rst_addr",  32'(bus.oCHAR_ADDR), 32'd0);

    // Power-up: init plus the first full draw.
    got.delete();
    exp_q.delete();
    add_draw(1'b1);
    #1 rst = 1'b0;
    wait_idle("init", 2000, 38);
    repeat (20) @(negedge clk);
    compare_list("init");
    check("idle_start", 32'(bus.oLCD_START), 32'd0);

    // Refresh from IDLE with fresh buffer contents.
    new_draw_expect();
    pulse_refresh(1'b1);
    wait_idle("refresh", 2000, 34);
    repeat (10) @(negedge clk);
    compare_list("refresh");

    // Several requests during a draw collapse into one extra redraw.
    new_draw_expect();
    add_draw(1'b0);
    pulse_refresh(1'b1);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(10, 70)) @(negedge clk);
      pulse_refresh(1'b0);
    end
    wait_idle("pend", 4000, 68);
    repeat (40) @(negedge clk);
    compare_list("pend");
    check("pend_idle", 32'(bus.oBUSY), 32'd0);

    // Reset during line 1 character 7 restarts the full init.
    new_draw_expect();
    pulse_refresh(1'b1);
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 1000 && !hit; c++) begin
        @(negedge clk);
        if (bus.oLCD_START && bus.oLCD_RS && bus.oCHAR_ADDR == 5'd7) hit = 1'b1;
      end
      check("rst_mid_found", 32'(hit), 32'd1);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_start", 32'(bus.oLCD_START), 32'd0);
    check("rst_mid_busy",  32'(bus.oBUSY),      32'd1);
    @(negedge clk);
    got.delete();
    exp_q.delete();
    randomize_mem();
    add_draw(1'b1);
    #1 rst = 1'b0;
    wait_idle("reinit", 2000, 38);
    compare_list("reinit");

    // Slow DONE, then a stray DONE pulse while idle.
    lat = 20;
    new_draw_expect();
    pulse_refresh(1'b1);
    wait_idle("slow", 4000, 34);
    compare_list("slow");
    got.delete();
    @(posedge clk);
    #2 done_force = 1'b1;
    @(posedge clk);
    #2 done_force = 1'b0;
    repeat (30) @(negedge clk);
    check("stray_done_xfers", 32'(got.size()), 32'd0);
    check("stray_done_busy",  32'(bus.oBUSY),  32'd0);

    // A final draw with a random controller latency.
    lat = $urandom_range(1, 6);
    new_draw_expect();
    pulse_refresh(1'b1);
    wait_idle("rand_lat", 2000, 34);
    compare_list("rand_lat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
